// File: rtl/updown_pkg.sv
// Shared encodings for the up/down counter direction sequencer.
package updown_pkg;

  typedef enum logic [1:0] {
    MODE_FREE_UP   = 2'b00,
    MODE_FREE_DOWN = 2'b01,
    MODE_BOUNCE    = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  // Encoded so that the state bit doubles as the up_down output.
  typedef enum logic {
    S_DN = 1'b0,
    S_UP = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/updown_dir_sequencer.sv
// Direction controller for a 4-bit up/down counter; in BOUNCE mode it turns
// one count early so the counter peaks exactly at HI and troughs at LO.
module updown_dir_sequencer
  import updown_pkg::*;
#(
  parameter int W  = 4,
  parameter int LO = 2,
  parameter int HI = 12,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  q_in,
  output logic          up_down,
  output logic          turn_pulse,
  output logic [CW-1:0] bounce_cnt,
  output logic          out_of_win
);

  if ((HI - LO < 2) || (HI > (2 ** W) - 1) || (LO < 0)) begin : g_bad_params
    $error("updown_dir_sequencer: illegal LO/HI window for width W");
  end

  localparam logic [W-1:0] LoV  = W'(LO);
  localparam logic [W-1:0] HiV  = W'(HI);
  localparam logic [W-1:0] LoP1 = W'(LO + 1);
  localparam logic [W-1:0] HiM1 = W'(HI - 1);

  state_e state_q, state_d;
  logic   turn_q, turn_d;
  logic   oow_q, oow_d;
  logic   valley_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_UP;
      turn_q  <= 1'b0;
      oow_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      turn_q  <= turn_d;
      oow_q   <= oow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    turn_d   = 1'b0;
    oow_d    = 1'b0;
    valley_d = 1'b0;
    unique case (mode_e'(mode))
      MODE_FREE_UP:   state_d = S_UP;
      MODE_FREE_DOWN: state_d = S_DN;
      MODE_HOLD:      state_d = state_q;
      MODE_BOUNCE: begin
        // Out-of-window recovery outranks the normal turn points.
        if (q_in > HiV) begin
          state_d = S_DN;
          oow_d   = 1'b1;
        end else if (q_in < LoV) begin
          state_d = S_UP;
          oow_d   = 1'b1;
        end else if ((state_q == S_UP) && (q_in >= HiM1)) begin
          state_d = S_DN;
          turn_d  = 1'b1;
        end else if ((state_q == S_DN) && (q_in <= LoP1)) begin
          state_d  = S_UP;
          turn_d   = 1'b1;
          valley_d = 1'b1;
        end
      end
      default: state_d = state_q;
    endcase
  end

  sat_counter #(.CW(CW)) u_bounce_cnt (
    .clk (clk),
    .rst (rst),
    .inc (valley_d),
    .cnt (bounce_cnt)
  );

  assign up_down    = (state_q == S_UP);
  assign turn_pulse = turn_q;
  assign out_of_win = oow_q;

endmodule
